demux1to4_seq: RTL and testbench

- Registered 1-to-4 demultiplexer: routes one WIDTH-bit input word to one of four held output lanes.
- Inverse of the team's 4-to-1 selector path. Fans a single data stream (switches or upstream logic) out to four LED/display lanes.
- Two modes: manual (lane picked by sel) and auto-scan (round-robin lane pointer with frame-complete pulse).

---
 rtl/demux_pkg.sv | 12 +
 rtl/lane_ptr_ctr.sv | 27 ++
 rtl/demux1to4_seq.sv | 97 +++++++++
 tb/tb_demux1to4_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and lane constants for demux1to4_seq
package demux_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;

endpackage

// File: rtl/lane_ptr_ctr.sv
// rtl/lane_ptr_ctr.sv - 2-bit lane pointer with sync clear, enable and wrap flag
module lane_ptr_ctr
  import demux_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  output logic [LANE_IDX_W-1:0] count,
  output logic                  wrap
);

  logic [LANE_IDX_W-1:0] r_count;

  // Clear beats enable so a mode-change edge always restarts at lane 0.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign wrap  = en && (r_count == LANE_IDX_W'(NUM_LANES - 1));

endmodule

// File: rtl/demux1to4_seq.sv
// rtl/demux1to4_seq.sv - registered 1-to-4 demux with manual select and auto-scan modes
module demux1to4_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       auto_mode,
  input  logic [LANE_IDX_W-1:0]      sel,
  output logic [NUM_LANES*WIDTH-1:0] out_lanes,
  output logic [NUM_LANES-1:0]       lane_strobe,
  output logic [LANE_IDX_W-1:0]      cur_lane,
  output logic                       frame_done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_lanes [NUM_LANES];
  logic [NUM_LANES-1:0]  r_strobe;
  logic                  r_frame_done;
  logic [LANE_IDX_W-1:0] r_sel;
  logic [LANE_IDX_W-1:0] w_ptr;
  logic                  w_ptr_wrap;
  logic                  w_ptr_clr;
  logic                  w_ptr_en;
  logic [LANE_IDX_W-1:0] w_wr_idx;
  logic                  w_frame;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_MANUAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A word arriving on a mode-change edge is routed under the old state.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_clr   = 1'b0;
    w_ptr_en    = 1'b0;
    w_wr_idx    = sel;
    w_frame     = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        w_ptr_clr = 1'b1;
        if (auto_mode) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        w_wr_idx = w_ptr;
        w_ptr_en = in_valid;
        w_frame  = w_ptr_wrap;
        if (!auto_mode) begin
          w_state_nxt = ST_MANUAL;
          w_ptr_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_MANUAL;
    endcase
  end

  lane_ptr_ctr u_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (w_ptr_clr),
    .en    (w_ptr_en),
    .count (w_ptr),
    .wrap  (w_ptr_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_LANES; k++) r_lanes[k] <= '0;
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      r_sel        <= '0;
    end else begin
      if (in_valid) r_lanes[w_wr_idx] <= in_data;
      r_strobe     <= in_valid ? (NUM_LANES'(1) << w_wr_idx) : '0;
      r_frame_done <= w_frame;
      r_sel        <= sel;
    end
  end

  always_comb begin
    out_lanes = '0;
    for (int k = 0; k < NUM_LANES; k++) out_lanes[k*WIDTH +: WIDTH] = r_lanes[k];
  end

  assign lane_strobe = r_strobe;
  assign frame_done  = r_frame_done;
  assign cur_lane    = (r_state == ST_SCAN) ? w_ptr : r_sel;

endmodule

// File: tb/tb_demux1to4_seq.sv
// tb/tb_demux1to4_seq.sv - directed self-checking bench for demux1to4_seq
module tb_demux1to4_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        auto_mode;
  logic [1:0]  sel;
  logic [15:0] out_lanes;
  logic [3:0]  lane_strobe;
  logic [1:0]  cur_lane;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  demux1to4_seq #(.WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .auto_mode   (auto_mode),
    .sel         (sel),
    .out_lanes   (out_lanes),
    .lane_strobe (lane_strobe),
    .cur_lane    (cur_lane),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_lanes, input logic [3:0] e_strobe,
                         input logic [1:0] e_cur, input logic e_done);
    chk({tag, ".lanes"}, 32'(out_lanes), 32'(e_lanes));
    chk({tag, ".strobe"}, 32'(lane_strobe), 32'(e_strobe));
    chk({tag, ".cur"}, 32'(cur_lane), 32'(e_cur));
    chk({tag, ".done"}, 32'(frame_done), 32'(e_done));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 4'hF; auto_mode = 1'b0; sel = 2'd0;
    tick(); tick();
    chk_all("reset", 16'h0000, 4'b0000, 2'd0, 1'b0);

    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk_all("idle", 16'h0000, 4'b0000, 2'd0, 1'b0);

    in_data = 4'hA; sel = 2'd2; in_valid = 1'b1;
    tick();
    chk_all("man_a", 16'h0A00, 4'b0100, 2'd2, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_all("man_hold", 16'h0A00, 4'b0000, 2'd2, 1'b0);
    in_data = 4'h5; sel = 2'd0; in_valid = 1'b1;
    tick();
    chk_all("man_5", 16'h0A05, 4'b0001, 2'd0, 1'b0);

    in_valid = 1'b0; auto_mode = 1'b1; sel = 2'd3;
    tick();
    chk_all("scan_enter", 16'h0A05, 4'b0000, 2'd0, 1'b0);
    in_valid = 1'b1;
    in_data = 4'h1; tick(); chk_all("f1_w1", 16'h0A01, 4'b0001, 2'd1, 1'b0);
    in_data = 4'h2; tick(); chk_all("f1_w2", 16'h0A21, 4'b0010, 2'd2, 1'b0);
    in_data = 4'h3; tick(); chk_all("f1_w3", 16'h0321, 4'b0100, 2'd3, 1'b0);
    in_data = 4'h4; tick(); chk_all("f1_w4", 16'h4321, 4'b1000, 2'd0, 1'b1);
    in_valid = 1'b0;
    tick(); chk_all("f1_after", 16'h4321, 4'b0000, 2'd0, 1'b0);

    in_valid = 1'b1; in_data = 4'h7;
    tick(); chk_all("gap_w7", 16'h4327, 4'b0001, 2'd1, 1'b0);
    in_valid = 1'b0;
    tick(); chk_all("gap_i1", 16'h4327, 4'b0000, 2'd1, 1'b0);
    tick(); tick(); chk_all("gap_i3", 16'h4327, 4'b0000, 2'd1, 1'b0);
    in_valid = 1'b1;
    in_data = 4'h8; tick(); chk_all("gap_w8", 16'h4387, 4'b0010, 2'd2, 1'b0);
    in_data = 4'h9; tick(); chk_all("gap_w9", 16'h4987, 4'b0100, 2'd3, 1'b0);
    in_data = 4'hA; tick(); chk_all("gap_wA", 16'hA987, 4'b1000, 2'd0, 1'b1);
    in_data = 4'hB; tick(); chk_all("wrap_wB", 16'hA98B, 4'b0001, 2'd1, 1'b0);
    in_valid = 1'b0;

    auto_mode = 1'b0; sel = 2'd1;
    tick(); chk_all("abort_prep", 16'hA98B, 4'b0000, 2'd1, 1'b0);
    auto_mode = 1'b1;
    tick(); chk("rescan_cur", 32'(cur_lane), 32'd0);
    in_valid = 1'b1;
    in_data = 4'h1; tick(); chk_all("ab_w1", 16'hA981, 4'b0001, 2'd1, 1'b0);
    in_data = 4'h2; tick(); chk_all("ab_w2", 16'hA921, 4'b0010, 2'd2, 1'b0);
    in_valid = 1'b0; auto_mode = 1'b0; sel = 2'd3;
    tick(); chk_all("ab_drop", 16'hA921, 4'b0000, 2'd3, 1'b0);
    in_valid = 1'b1; in_data = 4'h6;
    tick(); chk_all("ab_man6", 16'h6921, 4'b1000, 2'd3, 1'b0);
    in_valid = 1'b0; auto_mode = 1'b1;
    tick(); chk("ab_rescan_cur", 32'(cur_lane), 32'd0);
    in_valid = 1'b1; in_data = 4'hC;
    tick(); chk_all("ab_reenter", 16'h692C, 4'b0001, 2'd1, 1'b0);

    in_data = 4'hD;
    tick(); chk_all("mid_w2", 16'h69DC, 4'b0010, 2'd2, 1'b0);
    reset = 1'b1; in_data = 4'hE;
    tick(); chk_all("mid_reset", 16'h0000, 4'b0000, 2'd0, 1'b0);
    reset = 1'b0; auto_mode = 1'b0; in_valid = 1'b0; sel = 2'd2;
    tick(); chk_all("post_reset_man", 16'h0000, 4'b0000, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 4'hF;
    tick(); chk_all("post_reset_wr", 16'h0F00, 4'b0100, 2'd2, 1'b0);
    in_valid = 1'b0;
    tick(); chk_all("final", 16'h0F00, 4'b0000, 2'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
